fetch_pc_unit: RTL and testbench

Fetch-side consumer of the EX-stage branch/jump resolution. Owns the program counter and drives the instruction-memory read handshake. Applies redirects (`REDIRECT`, `REDIRECT_PC`, `FLUSH`), honours hazard stalls through a one-entry skid buffer, and presents the IF/ID pipeline register contents. A redirect in the middle of a memory access never corrupts the access; the stale instruction is discarded.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_skid_buffer.sv | 38 +++
 rtl/fetch_pc_unit.sv | 123 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC unit: state encoding, reset PC, NOP and PC step.
package fetch_pkg;

  typedef enum logic {
    ST_REQ     = 1'b0,
    ST_DISCARD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry PC/instruction holding register; clear wins over load, load wins over drain.
module fetch_skid_buffer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr
);
  import fetch_pkg::*;

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_instr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_pc    <= 32'h0;
      r_instr <= NOP_INSTR;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC owner: IMEM handshake, redirect/flush, stall skid buffer, IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN flags misaligned redirect targets for one cycle.
//
// IMEM handshake: IMEM_ADDRESS is held while IMEM_READ=1 and IMEM_BUSYWAIT=1; an
// access completes in the cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
module fetch_pc_unit
  import fetch_pkg::*;
(
  input  logic         CLK,
  input  logic         RESET,
  input  logic         REDIRECT,
  input  logic [31:0]  REDIRECT_PC,
  input  logic         FLUSH,
  input  logic         STALL,
  output logic [31:0]  IMEM_ADDRESS,
  output logic         IMEM_READ,
  input  logic [31:0]  IMEM_READDATA,
  input  logic         IMEM_BUSYWAIT,
  output logic [31:0]  IFID_PC,
  output logic [31:0]  IFID_INSTR,
  output logic         IFID_VALID,
  output logic         FETCH_MISALIGN,
  output fetch_state_t DBG_STATE
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_target;
  logic [31:0]  r_ifid_pc;
  logic [31:0]  r_ifid_instr;
  logic         r_ifid_valid;

  logic         w_buf_valid;
  logic [31:0]  w_buf_pc;
  logic [31:0]  w_buf_instr;
  logic         w_complete;
  logic         w_busy_access;
  logic [31:0]  w_target;
  logic         w_buf_load;
  logic         w_buf_drain;

  // In DISCARD the old access is still outstanding, so the address stays at the old PC.
  assign IMEM_ADDRESS  = r_pc;
  assign IMEM_READ     = (r_state == ST_DISCARD) || !w_buf_valid;
  assign w_complete    = IMEM_READ && !IMEM_BUSYWAIT;
  assign w_busy_access = IMEM_READ && IMEM_BUSYWAIT;
  assign w_target      = REDIRECT_PC & ~32'h3;
  assign w_buf_load    = !REDIRECT && STALL && (r_state == ST_REQ) && w_complete;
  assign w_buf_drain   = !REDIRECT && !STALL && w_buf_valid;

  fetch_skid_buffer u_skid (
    .i_clk   (CLK),
    .i_rst   (RESET),
    .i_load  (w_buf_load),
    .i_drain (w_buf_drain),
    .i_clear (REDIRECT),
    .i_pc    (r_pc),
    .i_instr (IMEM_READDATA),
    .o_valid (w_buf_valid),
    .o_pc    (w_buf_pc),
    .o_instr (w_buf_instr)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_REQ;
      r_pc         <= RESET_PC;
      r_target     <= RESET_PC;
      r_ifid_pc    <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_valid <= 1'b0;
    end else if (REDIRECT) begin
      if (FLUSH) r_ifid_valid <= 1'b0;
      if (w_busy_access) begin
        r_state  <= ST_DISCARD;
        r_target <= w_target;
      end else begin
        r_state <= ST_REQ;
        r_pc    <= w_target;
      end
    end else begin
      if (r_state == ST_DISCARD) begin
        if (w_complete) begin
          r_pc    <= r_target;
          r_state <= ST_REQ;
        end
      end else if (w_complete) begin
        r_pc <= r_pc + PC_INC;
      end
      // Without a stall IF/ID is consumed every cycle: refill from buffer, fetch, or bubble.
      if (!STALL) begin
        if (w_buf_valid) begin
          r_ifid_pc    <= w_buf_pc;
          r_ifid_instr <= w_buf_instr;
          r_ifid_valid <= 1'b1;
        end else if ((r_state == ST_REQ) && w_complete) begin
          r_ifid_pc    <= r_pc;
          r_ifid_instr <= IMEM_READDATA;
          r_ifid_valid <= 1'b1;
        end else begin
          r_ifid_valid <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge CLK) begin
    if (RESET) r_misalign <= 1'b0;
    else       r_misalign <= REDIRECT && (REDIRECT_PC[1:0] != 2'b00);
  end
  assign FETCH_MISALIGN = r_misalign;
`else
  assign FETCH_MISALIGN = 1'b0;
`endif

  assign IFID_PC    = r_ifid_pc;
  assign IFID_INSTR = r_ifid_valid ? r_ifid_instr : NOP_INSTR;
  assign IFID_VALID = r_ifid_valid;
  assign DBG_STATE  = r_state;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven bench for fetch_pc_unit with a small address-derived instruction memory.
module tb_fetch_pc_unit;
  import fetch_pkg::*;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic MIS_EN = 1'b1;
`else
  localparam logic MIS_EN = 1'b0;
`endif
  localparam logic [31:0] TAG = 32'hC000_0000;

  logic         clk;
  logic         rst;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         flush;
  logic         stall;
  logic [31:0]  imem_addr;
  logic         imem_read;
  logic [31:0]  imem_rdata;
  logic         imem_busy;
  logic [31:0]  ifid_pc;
  logic [31:0]  ifid_instr;
  logic         ifid_valid;
  logic         misalign;
  fetch_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         rst, rd, fl, st, bz;
    logic [31:0]  rpc;
    logic         chk_pre;
    logic [31:0]  ea;
    logic         er;
    logic         ev;
    logic [31:0]  ep;
    fetch_state_t es;
    logic         em;
  } vec_t;

  vec_t vq[$];

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = TAG | imem_addr;

  fetch_pc_unit dut (
    .CLK            (clk),
    .RESET          (rst),
    .REDIRECT       (redirect),
    .REDIRECT_PC    (redirect_pc),
    .FLUSH          (flush),
    .STALL          (stall),
    .IMEM_ADDRESS   (imem_addr),
    .IMEM_READ      (imem_read),
    .IMEM_READDATA  (imem_rdata),
    .IMEM_BUSYWAIT  (imem_busy),
    .IFID_PC        (ifid_pc),
    .IFID_INSTR     (ifid_instr),
    .IFID_VALID     (ifid_valid),
    .FETCH_MISALIGN (misalign),
    .DBG_STATE      (dbg_state)
  );

  function automatic vec_t mk(logic r, logic rd, logic fl, logic st, logic bz,
                              logic [31:0] rpc, logic chk, logic [31:0] ea, logic er,
                              logic ev, logic [31:0] ep, fetch_state_t es, logic em);
    vec_t v;
    v.rst = r; v.rd = rd; v.fl = fl; v.st = st; v.bz = bz; v.rpc = rpc;
    v.chk_pre = chk; v.ea = ea; v.er = er;
    v.ev = ev; v.ep = ep; v.es = es; v.em = em;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: apply one vector's inputs mid-cycle
  task automatic drive(input vec_t v);
    rst = v.rst; redirect = v.rd; flush = v.fl; stall = v.st; imem_busy = v.bz;
    redirect_pc = v.rpc;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; flush = 1'b0; stall = 1'b0; imem_busy = 1'b0;
    redirect_pc = 32'h0;

    //            rst rd fl st bz rpc           chk addr          rd  v  pc            state       mis
    vq.push_back(mk(1, 0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        ST_REQ,     0));
    // zero-wait run
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h4,        1, 1, 32'h4,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h8,        1, 1, 32'h8,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'hC,        1, 1, 32'hC,        ST_REQ,     0));
    // flushing redirect to 0x40
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h40,       1, 32'h10,       1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h40,       1, 1, 32'h40,       ST_REQ,     0));
    // redirect to 0x10, then busy 3 cycles with redirect to 0x80 in the second
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h10,       1, 32'h44,       1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0,        1, 32'h10,       1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h80,       1, 32'h10,       1, 0, 32'h0,        ST_DISCARD, 0));
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0,        1, 32'h10,       1, 0, 32'h0,        ST_DISCARD, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h10,       1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h80,       1, 1, 32'h80,       ST_REQ,     0));
    // stall for 3 cycles while PC 0x20 completes
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h1C,       1, 32'h84,       1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h1C,       1, 1, 32'h1C,       ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h20,       1, 1, 32'h1C,       ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h24,       0, 1, 32'h1C,       ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h24,       0, 1, 32'h1C,       ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h24,       0, 1, 32'h20,       ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h24,       1, 1, 32'h24,       ST_REQ,     0));
    // buffer fills, then stall+redirect to 0x100
    vq.push_back(mk(0, 0, 0, 1, 0, 32'h0,        1, 32'h28,       1, 1, 32'h24,       ST_REQ,     0));
    vq.push_back(mk(0, 1, 1, 1, 0, 32'h100,      1, 32'h2C,       0, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h100,      1, 1, 32'h100,      ST_REQ,     0));
    // non-flushing redirect keeps IF/ID
    vq.push_back(mk(0, 1, 0, 0, 0, 32'h200,      1, 32'h104,      1, 1, 32'h100,      ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h200,      1, 1, 32'h200,      ST_REQ,     0));
    // misaligned target
    vq.push_back(mk(0, 1, 1, 0, 0, 32'h43,       1, 32'h204,      1, 0, 32'h0,        ST_REQ,     MIS_EN));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h40,       1, 1, 32'h40,       ST_REQ,     0));
    // PC wrap
    vq.push_back(mk(0, 1, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'h44,      1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, ST_REQ,   0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h0,        ST_REQ,     0));
    // reset during DISCARD
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0,        1, 32'h4,        1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h300,      1, 32'h4,        1, 0, 32'h0,        ST_DISCARD, 0));
    vq.push_back(mk(1, 0, 0, 0, 1, 32'h0,        1, 32'h4,        1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h0,        1, 1, 32'h0,        ST_REQ,     0));
    // second redirect in DISCARD overwrites the target
    vq.push_back(mk(0, 0, 0, 0, 1, 32'h0,        1, 32'h4,        1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h500,      1, 32'h4,        1, 0, 32'h0,        ST_DISCARD, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 32'h600,      1, 32'h4,        1, 0, 32'h0,        ST_DISCARD, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h4,        1, 0, 32'h0,        ST_REQ,     0));
    vq.push_back(mk(0, 0, 0, 0, 0, 32'h0,        1, 32'h600,      1, 1, 32'h600,      ST_REQ,     0));

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      if (vq[i].chk_pre) begin
        chk($sformatf("v%0d imem_addr", i), imem_addr, vq[i].ea);
        chk($sformatf("v%0d imem_read", i), {31'h0, imem_read}, {31'h0, vq[i].er});
      end
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ifid_valid", i), {31'h0, ifid_valid}, {31'h0, vq[i].ev});
      if (vq[i].ev)
        chk($sformatf("v%0d ifid_pc", i), ifid_pc, vq[i].ep);
      chk($sformatf("v%0d ifid_instr", i), ifid_instr, vq[i].ev ? (TAG | vq[i].ep) : NOP_INSTR);
      chk($sformatf("v%0d state", i), {31'h0, dbg_state}, {31'h0, vq[i].es});
      chk($sformatf("v%0d misalign", i), {31'h0, misalign}, {31'h0, vq[i].em});
      if (i == 0)
        chk("reset ifid_pc", ifid_pc, 32'h0);
    end

    // random-length busy access at 0x604: address stable, then lands in IF/ID
    begin
      int n;
      n = $urandom_range(1, 5);
      rst = 1'b0; redirect = 1'b0; flush = 1'b0; stall = 1'b0; imem_busy = 1'b1;
      for (int k = 0; k < n; k++) begin
        #1;
        chk($sformatf("busy%0d addr", k), imem_addr, 32'h604);
        chk($sformatf("busy%0d read", k), {31'h0, imem_read}, 32'h1);
        @(posedge clk);
        #1;
        chk($sformatf("busy%0d valid", k), {31'h0, ifid_valid}, 32'h0);
      end
      imem_busy = 1'b0;
      @(posedge clk);
      #1;
      chk("busy done valid", {31'h0, ifid_valid}, 32'h1);
      chk("busy done pc", ifid_pc, 32'h604);
      chk("busy next addr", imem_addr, 32'h608);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
